// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// FSM state encoding and counter sizing.
// No datapath logic lives here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle for serial_adder.
// Purely structural, no latency.
// Backpressure is expressed through busy: start is ignored while it is high.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carryin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;

    modport master (
        output start, a, b, carryin,
        input  busy, done, sum, carryout, overflow
    );

    modport slave (
        input  start, a, b, carryin,
        output busy, done, sum, carryout, overflow
    );
endinterface

// File: rtl/add_bit_slice.sv
// One-bit full adder; the only arithmetic in the serial adder.
// Combinational, zero latency.
// No flow control.
module add_bit_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice fed LSB-first from shift registers.
// Latency WIDTH+1 cycles from the accepting edge to the done cycle (done is a 1-cycle pulse).
// start is taken only when busy=0 (IDLE or DONE); requests during RUN are dropped.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    serial_adder_if.slave bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] sha;
    logic [WIDTH-1:0] shb;
    logic [WIDTH-1:0] shr;
    logic             carry;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] sum_q;
    logic             carryout_q;
    logic             overflow_q;

    logic             s;
    logic             c;

    add_bit_slice u_slice (
        .a    (sha[0]),
        .b    (shb[0]),
        .cin  (carry),
        .s    (s),
        .cout (c)
    );

    assign last = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sha        <= '0;
            shb        <= '0;
            shr        <= '0;
            carry      <= 1'b0;
            count      <= '0;
            sum_q      <= '0;
            carryout_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (load) begin
            sha   <= bus.a;
            shb   <= bus.b;
            carry <= bus.carryin;
            count <= '0;
        end else if (step) begin
            sha   <= sha >> 1;
            shb   <= shb >> 1;
            shr   <= {s, shr[WIDTH-1:1]};
            carry <= c;
            count <= count + CW'(1);
            // On the MSB step, carry holds the carry into the MSB.
            if (last) begin
                sum_q      <= {s, shr[WIDTH-1:1]};
                carryout_q <= c;
                overflow_q <= carry ^ c;
            end
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.carryout = carryout_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One add from an idle DUT; sum must hold prev until done.
    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] prev,
                           input logic [7:0] exp_sum, input logic exp_co, input logic exp_ov);
        int n;
        bit held;
        @(negedge clk);
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        bus.a       = a;
        bus.b       = b;
        bus.carryin = cin;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n    = 1;
        held = 1'b1;
        while (!bus.done && n < 20) begin
            if (bus.sum !== prev) held = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_hold"}, 32'(held), 32'd1);
        check({tag, "_lat"}, 32'(n), 32'd9);
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
        check({tag, "_co"}, 32'(bus.carryout), 32'(exp_co));
        check({tag, "_ov"}, 32'(bus.overflow), 32'(exp_ov));
        check({tag, "_dbusy"}, 32'(bus.busy), 32'd0);
    endtask

    logic [7:0] va [4] = '{8'h5A, 8'h7F, 8'hC0, 8'h0F};
    logic [7:0] vb [4] = '{8'h3C, 8'h01, 8'hC0, 8'hF0};
    logic       vc [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int n;
        int pulses;
        logic [8:0] full;
        logic       ov;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.carryin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_co", 32'(bus.carryout), 32'd0);
        check("rst_ov", 32'(bus.overflow), 32'd0);
        reset = 1'b0;

        run_add("t1", 8'h5A, 8'h3C, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);
        run_add("t2", 8'hFF, 8'h01, 1'b0, 8'h96, 8'h00, 1'b1, 1'b0);
        run_add("t3", 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        run_add("t4", 8'h00, 8'h00, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0);

        // start re-pulsed mid-RUN with new operands must be ignored
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.carryin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        n = 3;
        bus.a = 8'h11; bus.b = 8'h11; bus.start = 1'b1;
        @(negedge clk);
        n++;
        bus.start = 1'b0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rp_lat", 32'(n), 32'd9);
        check("rp_sum", 32'(bus.sum), 32'h46);
        check("rp_co", 32'(bus.carryout), 32'd0);
        check("rp_ov", 32'(bus.overflow), 32'd0);
        pulses = 0;
        repeat (12) begin
            if (bus.done) pulses++;
            @(negedge clk);
        end
        check("rp_pulses", 32'(pulses), 32'd1);

        // reset four cycles into RUN aborts the add
        bus.a = 8'hFF; bus.b = 8'h01; bus.carryin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_sum", 32'(bus.sum), 32'd0);
        check("ab_done", 32'(bus.done), 32'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("ab_pulses", 32'(pulses), 32'd0);
        run_add("t6", 8'h01, 8'h02, 1'b0, 8'h00, 8'h03, 1'b0, 1'b0);

        // start held high: each DONE cycle accepts the next vector
        @(negedge clk);
        bus.a = va[0]; bus.b = vb[0]; bus.carryin = vc[0]; bus.start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                bus.a = va[k+1]; bus.b = vb[k+1]; bus.carryin = vc[k+1];
            end else begin
                bus.start = 1'b0;
            end
            n = 1;
            while (!bus.done && n < 20) begin
                @(negedge clk);
                n++;
            end
            full = 9'(va[k]) + 9'(vb[k]) + 9'(vc[k]);
            ov   = (va[k][7] == vb[k][7]) && (full[7] != va[k][7]);
            check($sformatf("bb%0d_period", k), 32'(n), 32'd9);
            check($sformatf("bb%0d_sum", k), 32'(bus.sum), 32'(full[7:0]));
            check($sformatf("bb%0d_co", k), 32'(bus.carryout), 32'(full[8]));
            check($sformatf("bb%0d_ov", k), 32'(bus.overflow), 32'(ov));
            @(negedge clk);
        end
        check("bb_end_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
